// File: rtl/nvio_pkg.sv
// Shared state encodings for the nvio arithmetic blocks (divider and multiplier).
package nvio_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DIV       = 2'd1;
    localparam logic [1:0] DONE      = 2'd2;

    localparam logic [1:0] MUL_IDLE  = 2'd0;
    localparam logic [1:0] MUL_BUSY  = 2'd1;
    localparam logic [1:0] MUL_DONE  = 2'd2;

endpackage

// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per clock, signed, unsigned and
// mixed-sign modes, divide-by-zero flag and abort.
module divider
    import nvio_pkg::*;
#(
    parameter int WID = 80
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld,
    input  logic           abort,
    input  logic           sgn,
    input  logic           sgnus,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic [WID-1:0] q,
    output logic [WID-1:0] r,
    output logic           dvByZr,
    output logic           done,
    output logic           idle
);

    localparam int CW = $clog2(WID);

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [WID:0]   rem_r;
    logic [WID-1:0] dvd_r;
    logic [WID-1:0] dvs_r;
    logic           qs_r;
    logic           rs_r;
    logic [WID-1:0] q_r;
    logic [WID-1:0] r_r;
    logic           dvz_r;

    logic           b_zero_s;
    logic [WID-1:0] mag_a_s;
    logic [WID-1:0] mag_b_s;
    logic           qs_s;
    logic           rs_s;
    logic [WID+1:0] shift_s;
    logic [WID+1:0] trial_s;
    logic           neg_s;
    logic [WID:0]   rem_nxt_s;
    logic [WID-1:0] quo_nxt_s;
    logic [WID-1:0] quo_fin_s;
    logic [WID-1:0] rem_fin_s;

    // Operand magnitudes and result signs selected by mode; sgnus outranks sgn.
    always_comb begin
        b_zero_s = (b == {WID{1'b0}});
        if ((sgn || sgnus) && a[WID-1]) begin
            mag_a_s = -a;
        end else begin
            mag_a_s = a;
        end
        if (sgn && !sgnus && b[WID-1]) begin
            mag_b_s = -b;
        end else begin
            mag_b_s = b;
        end
        if (sgnus) begin
            qs_s = a[WID-1];
        end else if (sgn) begin
            qs_s = a[WID-1] ^ b[WID-1];
        end else begin
            qs_s = 1'b0;
        end
        rs_s = (sgn || sgnus) ? a[WID-1] : 1'b0;
    end

    // One restoring step; the extra top bit of the trial difference is the borrow.
    always_comb begin
        shift_s   = {rem_r, dvd_r[WID-1]};
        trial_s   = shift_s - {2'b00, dvs_r};
        neg_s     = trial_s[WID+1];
        if (neg_s) begin
            rem_nxt_s = shift_s[WID:0];
        end else begin
            rem_nxt_s = trial_s[WID:0];
        end
        quo_nxt_s = {dvd_r[WID-2:0], ~neg_s};
        quo_fin_s = qs_r ? -quo_nxt_s : quo_nxt_s;
        rem_fin_s = rs_r ? -rem_nxt_s[WID-1:0] : rem_nxt_s[WID-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; unknown encodings recover to IDLE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (ld) begin
                    state_nxt_s = b_zero_s ? DONE : DIV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIV: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DIV;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Status outputs; done also reports an idle block that is not being loaded.
    always_comb begin
        idle = (state_r == IDLE);
        done = (state_r == DONE) || ((state_r == IDLE) && !ld);
    end

    // Operand load, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            rem_r <= {(WID+1){1'b0}};
            dvd_r <= {WID{1'b0}};
            dvs_r <= {WID{1'b0}};
            qs_r  <= 1'b0;
            rs_r  <= 1'b0;
            q_r   <= {WID{1'b0}};
            r_r   <= {WID{1'b0}};
            dvz_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ld && b_zero_s) begin
                        q_r   <= {WID{1'b1}};
                        r_r   <= a;
                        dvz_r <= 1'b1;
                    end else if (ld) begin
                        dvd_r <= mag_a_s;
                        dvs_r <= mag_b_s;
                        rem_r <= {(WID+1){1'b0}};
                        cnt_r <= CW'(WID - 1);
                        qs_r  <= qs_s;
                        rs_r  <= rs_s;
                        dvz_r <= 1'b0;
                    end
                end
                DIV: begin
                    if (!abort) begin
                        rem_r <= rem_nxt_s;
                        dvd_r <= quo_nxt_s;
                        cnt_r <= cnt_r - CW'(1);
                        if (cnt_r == {CW{1'b0}}) begin
                            q_r <= quo_fin_s;
                            r_r <= rem_fin_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q      = q_r;
    assign r      = r_r;
    assign dvByZr = dvz_r;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (WID=80): expected results are queued when an
// operation is launched and compared when the block reports DONE.
module tb_divider;

    localparam int W = 80;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         ld;
    logic         abort;
    logic         sgn;
    logic         sgnus;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dvByZr;
    logic         done;
    logic         idle;

    exp_t sb[$];
    int   checks;
    int   errors;

    divider #(.WID(W)) dut (
        .clk(clk), .rst(rst), .ld(ld), .abort(abort), .sgn(sgn), .sgnus(sgnus),
        .a(a), .b(b), .q(q), .r(r), .dvByZr(dvByZr), .done(done), .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait for the DONE state; cyc = edges after the ld edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic tu, output int cyc);
        a = ta; b = tb_v; sgn = ts; sgnus = tu; ld = 1'b1;
        step();
        ld = 1'b0;
        cyc = 0;
        while (!(done && !idle) && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    // Independent reference using native 80-bit unsigned division on magnitudes.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic ms, input logic mu);
        exp_t e;
        logic [W-1:0] ua, ub, uq, ur;
        logic qneg, rneg;
        if (mb == {W{1'b0}}) begin
            e.q = {W{1'b1}}; e.r = ma; e.z = 1'b1;
            return e;
        end
        ua   = ((ms || mu) && ma[W-1]) ? (~ma + 80'd1) : ma;
        ub   = (ms && !mu && mb[W-1]) ? (~mb + 80'd1) : mb;
        uq   = ua / ub;
        ur   = ua % ub;
        qneg = mu ? ma[W-1] : (ms ? (ma[W-1] ^ mb[W-1]) : 1'b0);
        rneg = (ms || mu) ? ma[W-1] : 1'b0;
        e.q  = qneg ? (~uq + 80'd1) : uq;
        e.r  = rneg ? (~ur + 80'd1) : ur;
        e.z  = 1'b0;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; ld = 1'b0; abort = 1'b0; sgn = 1'b0; sgnus = 1'b0;
        a = 80'd0; b = 80'd0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (q !== 80'd0 || r !== 80'd0 || dvByZr !== 1'b0 || idle !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL reset: q=%h r=%h z=%b idle=%b done=%b, want all zero, idle=1 done=1",
                     q, r, dvByZr, idle, done);
        end
    endtask

    task automatic test_unsigned();
        int cyc;
        exp_t e;
        sb.push_back('{q: 80'd14, r: 80'd2, z: 1'b0});
        run_op(80'd100, 80'd7, 1'b0, 1'b0, cyc);
        // ld cycle + 80 DIV cycles + 1 DONE cycle: DONE is seen 80 edges after ld.
        checks++;
        if (cyc !== 80) begin
            errors++;
            $display("FAIL unsigned_latency: %0d edges, want 80", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (q !== e.q || r !== e.r || dvByZr !== e.z) begin
            errors++;
            $display("FAIL unsigned: q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b", q, r, dvByZr, e.q, e.r, e.z);
        end
        step();
        checks++;
        if (idle !== 1'b1 || q !== 80'd14) begin
            errors++;
            $display("FAIL done_one_cycle: idle=%b q=%0d, want idle=1 q=14", idle, q);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] ta[3];
        logic [W-1:0] tb_v[3];
        logic [W-1:0] eq[3];
        logic [W-1:0] er[3];
        int cyc;
        exp_t e;
        ta[0] = -80'd100;                  tb_v[0] = 80'd7;
        eq[0] = -80'd14;                   er[0]   = -80'd2;
        ta[1] = 80'd100;                   tb_v[1] = -80'd7;
        eq[1] = -80'd14;                   er[1]   = 80'd2;
        ta[2] = {1'b1, {(W-1){1'b0}}};     tb_v[2] = {W{1'b1}};
        eq[2] = {1'b1, {(W-1){1'b0}}};     er[2]   = 80'd0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{q: eq[i], r: er[i], z: 1'b0});
            run_op(ta[i], tb_v[i], 1'b1, 1'b0, cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 80 || q !== e.q || r !== e.r || dvByZr !== e.z) begin
                errors++;
                $display("FAIL signed[%0d]: cyc=%0d q=%h r=%h z=%b, want q=%h r=%h z=0",
                         i, cyc, q, r, dvByZr, e.q, e.r);
            end
            step();
        end
    endtask

    task automatic test_mixed();
        int cyc;
        exp_t e;
        // Second pass also raises sgn to show sgnus keeps the divisor unsigned.
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{q: 80'd0, r: -80'd100, z: 1'b0});
            run_op(-80'd100, {1'b1, {(W-1){1'b0}}}, (i == 1), 1'b1, cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 80 || q !== e.q || r !== e.r || dvByZr !== e.z) begin
                errors++;
                $display("FAIL mixed[%0d]: cyc=%0d q=%h r=%h z=%b, want q=%h r=%h z=0",
                         i, cyc, q, r, dvByZr, e.q, e.r);
            end
            step();
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        exp_t e;
        sb.push_back('{q: {W{1'b1}}, r: 80'd55, z: 1'b1});
        run_op(80'd55, 80'd0, 1'b0, 1'b0, cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 0 || q !== e.q || r !== e.r || dvByZr !== e.z) begin
            errors++;
            $display("FAIL div_zero: cyc=%0d q=%h r=%0d z=%b, want cyc=0 q=%h r=55 z=1",
                     cyc, q, r, dvByZr, e.q);
        end
        step();
        sb.push_back('{q: 80'd3, r: 80'd1, z: 1'b0});
        run_op(80'd10, 80'd3, 1'b0, 1'b0, cyc);
        e = sb.pop_front();
        checks++;
        if (q !== e.q || r !== e.r || dvByZr !== e.z) begin
            errors++;
            $display("FAIL after_div_zero: q=%0d r=%0d z=%b, want q=3 r=1 z=0", q, r, dvByZr);
        end
        step();
    endtask

    task automatic test_abort();
        int cyc;
        exp_t e;
        a = {W{1'b1}}; b = 80'd3; sgn = 1'b0; sgnus = 1'b0; ld = 1'b1;
        step();
        ld = 1'b0;
        for (int i = 0; i < 39; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (idle !== 1'b1 || q !== 80'd3 || r !== 80'd1 || dvByZr !== 1'b0) begin
            errors++;
            $display("FAIL abort: idle=%b q=%0d r=%0d z=%b, want idle=1 q=3 r=1 z=0", idle, q, r, dvByZr);
        end
        // abort together with ld in IDLE must not block the start.
        sb.push_back('{q: 80'd3, r: 80'd0, z: 1'b0});
        abort = 1'b1;
        a = 80'd9; b = 80'd3; ld = 1'b1;
        step();
        ld = 1'b0; abort = 1'b0;
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_ld: idle=%b, want 0", idle);
        end
        cyc = 0;
        while (!(done && !idle) && cyc < 200) begin
            step();
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (cyc !== 80 || q !== e.q || r !== e.r) begin
            errors++;
            $display("FAIL after_abort: cyc=%0d q=%0d r=%0d, want cyc=80 q=3 r=0", cyc, q, r);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int starts;
        int cyc;
        logic prev_idle;
        exp_t e;
        a = 80'd1000; b = 80'd7; ld = 1'b1;
        step();
        ld = 1'b0;
        for (int i = 0; i < 19; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (q !== 80'd0 || r !== 80'd0 || idle !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: q=%0d r=%0d idle=%b done=%b, want 0 0 1 1", q, r, idle, done);
        end
        // ld held high from the start through DONE launches one operation only.
        sb.push_back('{q: 80'd3, r: 80'd2, z: 1'b0});
        a = 80'd20; b = 80'd6; ld = 1'b1;
        starts = 0; cyc = 0; prev_idle = idle;
        while (!(done && !idle) && cyc < 200) begin
            step();
            cyc++;
            if (prev_idle && !idle) starts++;
            prev_idle = idle;
        end
        e = sb.pop_front();
        checks++;
        if (cyc !== 81 || q !== e.q || r !== e.r || done !== 1'b1) begin
            errors++;
            $display("FAIL ld_held: cyc=%0d q=%0d r=%0d done=%b, want cyc=81 q=3 r=2 done=1", cyc, q, r, done);
        end
        step();
        ld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (prev_idle && !idle) starts++;
            prev_idle = idle;
            step();
        end
        checks++;
        if (starts !== 1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_op: starts=%0d idle=%b, want 1 1", starts, idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [95:0] ra;
        logic [95:0] rb;
        logic [W-1:0] ta;
        logic [W-1:0] tb_v;
        logic ts, tu;
        int cyc;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            ra   = {$urandom(), $urandom(), $urandom()};
            rb   = {$urandom(), $urandom(), $urandom()};
            ta   = ra[W-1:0];
            tb_v = rb[W-1:0] >> $urandom_range(0, 78);
            if (i[0]) tb_v = ~tb_v;
            ts   = 1'($urandom_range(0, 1));
            tu   = 1'($urandom_range(0, 1));
            sb.push_back(model(ta, tb_v, ts, tu));
            run_op(ta, tb_v, ts, tu, cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 80 || q !== e.q || r !== e.r || dvByZr !== e.z) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h s=%b su=%b cyc=%0d q=%h r=%h, want q=%h r=%h",
                         i, ta, tb_v, ts, tu, cyc, q, r, e.q, e.r);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ld = 1'b0; abort = 1'b0; sgn = 1'b0; sgnus = 1'b0;
        a = 80'd0; b = 80'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_mixed();
        test_div_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
